// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared constants and types for the VGA text VRAM arbiter
package vga_text_pkg;

  localparam int VRAM_WORDS = 600;
  localparam int CTRL_ADDR  = 600;
  localparam logic [31:0] CTRL_RESET = 32'h01FFE000;

  typedef enum logic {
    IDLE,
    AVL_RD
  } arb_state_t;

  typedef enum logic [1:0] {
    SRC_RAM,
    SRC_CTRL,
    SRC_ZERO
  } rd_src_t;

endpackage

// File: rtl/vga_ctrl_reg.sv
// rtl/vga_ctrl_reg.sv - byte-laned colour control register
module vga_ctrl_reg
  import vga_text_pkg::*;
#(
  parameter int               DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = CTRL_RESET
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   q_o
);

  logic [DATA_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (we_i) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (be_i[b]) q_d[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) q_q <= RESET_VAL;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter between Avalon slave and display fetcher
module vram_arbiter
  import vga_text_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int VRAM_WORDS = 600,
  parameter int CTRL_ADDR  = 600,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              AVL_CS,
  input  logic              AVL_READ,
  input  logic              AVL_WRITE,
  input  logic [3:0]        AVL_BYTE_EN,
  input  logic [ADDR_W-1:0] AVL_ADDR,
  input  logic [DATA_W-1:0] AVL_WRITEDATA,
  output logic [DATA_W-1:0] AVL_READDATA,
  output logic              AVL_WAITREQUEST,
  input  logic              DISP_REQ,
  input  logic [ADDR_W-1:0] DISP_ADDR,
  output logic              DISP_GNT,
  output logic [DATA_W-1:0] DISP_RDATA,
  output logic              DISP_RVALID,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_WE,
  output logic [3:0]        RAM_BE,
  output logic [DATA_W-1:0] RAM_WDATA,
  input  logic [DATA_W-1:0] RAM_RDATA,
  output logic [DATA_W-1:0] CTRL_OUT
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t    state_q, state_d;
  rd_src_t       src_q, src_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          disp_rvalid_q;

  logic avl_req, is_ram, is_ctrl, avl_ram_pend, starved;
  logic avl_gnt, disp_gnt, ctrl_we;

  assign avl_req      = AVL_CS && (AVL_READ || AVL_WRITE) && (state_q == IDLE);
  assign is_ram       = AVL_ADDR < ADDR_W'(VRAM_WORDS);
  assign is_ctrl      = AVL_ADDR == ADDR_W'(CTRL_ADDR);
  assign avl_ram_pend = avl_req && is_ram;
  assign starved      = starve_q == SW'(STARVE_MAX);

  // Display wins unless a starved Avalon RAM access is waiting.
  assign disp_gnt = RESET && DISP_REQ && !(avl_ram_pend && starved);
  assign avl_gnt  = RESET && avl_ram_pend && !disp_gnt;
  assign ctrl_we  = RESET && avl_req && AVL_WRITE && is_ctrl;

  vga_ctrl_reg #(
    .DATA_W    (DATA_W),
    .RESET_VAL (DATA_W'(CTRL_RESET))
  ) u_ctrl (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .we_i    (ctrl_we),
    .be_i    (AVL_BYTE_EN),
    .wdata_i (AVL_WRITEDATA),
    .q_o     (CTRL_OUT)
  );

  always_comb begin
    state_d         = state_q;
    src_d           = src_q;
    starve_d        = starve_q;
    AVL_WAITREQUEST = AVL_CS;
    AVL_READDATA    = '0;
    RAM_ADDR        = '0;
    RAM_WE          = 1'b0;
    RAM_BE          = 4'b0;
    RAM_WDATA       = '0;

    if (disp_gnt) RAM_ADDR = DISP_ADDR;
    if (avl_gnt) begin
      RAM_ADDR  = AVL_ADDR;
      RAM_WE    = AVL_WRITE && (AVL_BYTE_EN != 4'b0);
      RAM_BE    = AVL_WRITE ? AVL_BYTE_EN : 4'b0;
      RAM_WDATA = AVL_WRITE ? AVL_WRITEDATA : '0;
    end

    if (avl_ram_pend) begin
      if (avl_gnt)       starve_d = '0;
      else if (!starved) starve_d = starve_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (RESET && avl_req && (!is_ram || avl_gnt)) begin
          if (AVL_WRITE) begin
            AVL_WAITREQUEST = 1'b0;
          end else begin
            state_d = AVL_RD;
            src_d   = is_ram ? SRC_RAM : (is_ctrl ? SRC_CTRL : SRC_ZERO);
          end
        end
      end
      AVL_RD: begin
        if (RESET) begin
          AVL_WAITREQUEST = 1'b0;
          state_d         = IDLE;
          case (src_q)
            SRC_RAM:  AVL_READDATA = RAM_RDATA;
            SRC_CTRL: AVL_READDATA = CTRL_OUT;
            default:  AVL_READDATA = '0;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q       <= IDLE;
      src_q         <= SRC_RAM;
      starve_q      <= '0;
      disp_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      starve_q      <= starve_d;
      disp_rvalid_q <= disp_gnt;
    end
  end

  // Gating with RESET discards a fetch whose return cycle coincides with reset.
  assign DISP_GNT    = disp_gnt;
  assign DISP_RVALID = RESET && disp_rvalid_q;
  assign DISP_RDATA  = DISP_RVALID ? RAM_RDATA : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter
module tb_vram_arbiter;

  localparam int NW = 600;
  localparam int CA = 600;
  localparam int SMAX = 4;
  localparam logic [31:0] CTRL_RST = 32'h01FFE000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        AVL_CS = 1'b0, AVL_READ = 1'b0, AVL_WRITE = 1'b0;
  logic [3:0]  AVL_BYTE_EN = 4'h0;
  logic [9:0]  AVL_ADDR = '0;
  logic [31:0] AVL_WRITEDATA = '0;
  logic [31:0] AVL_READDATA;
  logic        AVL_WAITREQUEST;
  logic        DISP_REQ = 1'b0;
  logic [9:0]  DISP_ADDR = '0;
  logic        DISP_GNT;
  logic [31:0] DISP_RDATA;
  logic        DISP_RVALID;
  logic [9:0]  RAM_ADDR;
  logic        RAM_WE;
  logic [3:0]  RAM_BE;
  logic [31:0] RAM_WDATA;
  logic [31:0] RAM_RDATA;
  logic [31:0] CTRL_OUT;

  int total = 0;
  int bad = 0;

  logic [31:0] ram [0:NW-1];
  logic [31:0] ref_mem [0:NW-1];
  logic [31:0] ref_ctrl;
  bit          ram_ready = 1'b0;

  vram_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA), .AVL_WAITREQUEST(AVL_WAITREQUEST),
    .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR), .DISP_GNT(DISP_GNT),
    .DISP_RDATA(DISP_RDATA), .DISP_RVALID(DISP_RVALID),
    .RAM_ADDR(RAM_ADDR), .RAM_WE(RAM_WE), .RAM_BE(RAM_BE), .RAM_WDATA(RAM_WDATA),
    .RAM_RDATA(RAM_RDATA), .CTRL_OUT(CTRL_OUT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] seed_val(input int i);
    logic [31:0] v;
    v = (i * 32'h9E3779B1) ^ 32'h5A5A1234;
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Synchronous single-port VRAM macro model
  always @(posedge CLK) begin
    if (!ram_ready) begin
      for (int i = 0; i < NW; i++) ram[i] <= seed_val(i);
      ram_ready <= 1'b1;
    end else if (RAM_WE && RAM_ADDR < NW) begin
      for (int b = 0; b < 4; b++)
        if (RAM_BE[b]) ram[RAM_ADDR][8*b +: 8] <= RAM_WDATA[8*b +: 8];
    end
    RAM_RDATA <= (RAM_ADDR < NW) ? ram[RAM_ADDR] : 32'h0BADC0DE;
  end

  task automatic avl_op(input bit wr, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be,
                        output int lat, output int we_cnt, output logic [9:0] we_addr,
                        output logic [31:0] rdata);
    bit done;
    AVL_CS = 1'b1; AVL_READ = !wr; AVL_WRITE = wr;
    AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    lat = 0; we_cnt = 0; we_addr = '0; rdata = '0; done = 1'b0;
    while (!done && lat < 20) begin
      @(negedge CLK);
      lat++;
      if (RAM_WE) begin we_cnt++; we_addr = RAM_ADDR; end
      if (!AVL_WAITREQUEST) begin done = 1'b1; rdata = AVL_READDATA; end
      @(posedge CLK); #1;
    end
    AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b0; AVL_CS = 1'b1; AVL_READ = 1'b1; DISP_REQ = 1'b1; DISP_ADDR = 10'd3;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total++; if (AVL_WAITREQUEST !== 1'b1) begin bad++; $display("FAIL reset_waitreq_cs: got %b expected 1", AVL_WAITREQUEST); end
    total++; if (DISP_GNT !== 1'b0) begin bad++; $display("FAIL reset_disp_gnt: got %b expected 0", DISP_GNT); end
    total++; if (DISP_RVALID !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b expected 0", DISP_RVALID); end
    total++; if ({RAM_WE, RAM_BE, RAM_ADDR, RAM_WDATA} !== '0) begin bad++; $display("FAIL reset_ram_pins: got we=%b be=%h addr=%h wd=%h expected all 0", RAM_WE, RAM_BE, RAM_ADDR, RAM_WDATA); end
    total++; if (AVL_READDATA !== 32'h0 || DISP_RDATA !== 32'h0) begin bad++; $display("FAIL reset_rdata: got avl=%h disp=%h expected 0", AVL_READDATA, DISP_RDATA); end
    total++; if (CTRL_OUT !== CTRL_RST) begin bad++; $display("FAIL reset_ctrl: got %h expected %h", CTRL_OUT, CTRL_RST); end
    @(posedge CLK); #1;
    AVL_CS = 1'b0; AVL_READ = 1'b0; DISP_REQ = 1'b0;
    @(negedge CLK);
    total++; if (AVL_WAITREQUEST !== 1'b0) begin bad++; $display("FAIL reset_waitreq_nocs: got %b expected 0", AVL_WAITREQUEST); end
    @(posedge CLK); #1;
    RESET = 1'b1;
    ref_ctrl = CTRL_RST;
  endtask

  task automatic test_ctrl();
    int lat, wc; logic [9:0] wa; logic [31:0] rd;
    avl_op(1'b1, 10'(CA), 32'h0000AB00, 4'b0010, lat, wc, wa, rd);
    ref_ctrl = merge(ref_ctrl, 32'h0000AB00, 4'b0010);
    total++; if (lat != 1 || wc != 0) begin bad++; $display("FAIL ctrl_write_lat: got lat=%0d we=%0d expected lat=1 we=0", lat, wc); end
    total++; if (CTRL_OUT !== ref_ctrl) begin bad++; $display("FAIL ctrl_out: got %h expected %h", CTRL_OUT, ref_ctrl); end
    avl_op(1'b0, 10'(CA), 32'h0, 4'h0, lat, wc, wa, rd);
    total++; if (lat != 2 || wc != 0) begin bad++; $display("FAIL ctrl_read_lat: got lat=%0d we=%0d expected lat=2 we=0", lat, wc); end
    total++; if (rd !== ref_ctrl) begin bad++; $display("FAIL ctrl_read_data: got %h expected %h", rd, ref_ctrl); end
  endtask

  task automatic test_write_read();
    int lat, wc; logic [9:0] wa; logic [31:0] rd, d;
    avl_op(1'b1, 10'd5, 32'hDEADBEEF, 4'hF, lat, wc, wa, rd);
    ref_mem[5] = merge(ref_mem[5], 32'hDEADBEEF, 4'hF);
    total++; if (lat != 1 || wc != 1 || wa !== 10'd5) begin bad++; $display("FAIL wr5: got lat=%0d we=%0d addr=%0d expected 1/1/5", lat, wc, wa); end
    avl_op(1'b0, 10'd5, 32'h0, 4'h0, lat, wc, wa, rd);
    total++; if (lat != 2 || rd !== ref_mem[5]) begin bad++; $display("FAIL rd5: got lat=%0d data=%h expected lat=2 data=%h", lat, rd, ref_mem[5]); end
    d = $urandom;
    avl_op(1'b1, 10'd9, d, 4'b0000, lat, wc, wa, rd);
    total++; if (lat != 1) begin bad++; $display("FAIL wr9_be0_lat: got %0d expected 1", lat); end
    avl_op(1'b0, 10'd9, 32'h0, 4'h0, lat, wc, wa, rd);
    total++; if (rd !== ref_mem[9]) begin bad++; $display("FAIL rd9_be0: got %h expected %h", rd, ref_mem[9]); end
    d = $urandom;
    avl_op(1'b1, 10'd11, d, 4'b0101, lat, wc, wa, rd);
    ref_mem[11] = merge(ref_mem[11], d, 4'b0101);
    avl_op(1'b0, 10'd11, 32'h0, 4'h0, lat, wc, wa, rd);
    total++; if (rd !== ref_mem[11]) begin bad++; $display("FAIL rd11_partial: got %h expected %h", rd, ref_mem[11]); end
  endtask

  task automatic test_oob();
    int lat, wc; logic [9:0] wa; logic [31:0] rd;
    avl_op(1'b1, 10'd700, 32'h12345678, 4'hF, lat, wc, wa, rd);
    total++; if (lat != 1 || wc != 0) begin bad++; $display("FAIL oob_write: got lat=%0d we=%0d expected 1/0", lat, wc); end
    avl_op(1'b0, 10'd700, 32'h0, 4'h0, lat, wc, wa, rd);
    total++; if (lat != 2 || rd !== 32'h0) begin bad++; $display("FAIL oob_read: got lat=%0d data=%h expected 2/0", lat, rd); end
  endtask

  task automatic test_starvation();
    logic [31:0] exp_q[$];
    logic [31:0] d, e;
    bit prev_g, exp_g;
    prev_g = 1'b0;
    d = $urandom;
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 10'd7; AVL_WRITEDATA = d; AVL_BYTE_EN = 4'hF;
    for (int k = 1; k <= 10; k++) begin
      DISP_REQ = 1'b1; DISP_ADDR = 10'($urandom_range(0, NW-1));
      @(negedge CLK);
      exp_g = (k != SMAX + 1);
      total++; if (DISP_GNT !== exp_g) begin bad++; $display("FAIL starve_gnt c%0d: got %b expected %b", k, DISP_GNT, exp_g); end
      if (k == SMAX + 1) begin
        total++; if (AVL_WAITREQUEST !== 1'b0 || RAM_WE !== 1'b1 || RAM_ADDR !== 10'd7) begin bad++; $display("FAIL starve_avl_grant: got wait=%b we=%b addr=%0d expected 0/1/7", AVL_WAITREQUEST, RAM_WE, RAM_ADDR); end
      end else if (k < SMAX + 1) begin
        total++; if (AVL_WAITREQUEST !== 1'b1) begin bad++; $display("FAIL starve_wait c%0d: got %b expected 1", k, AVL_WAITREQUEST); end
      end
      total++; if (DISP_RVALID !== prev_g) begin bad++; $display("FAIL starve_rvalid c%0d: got %b expected %b", k, DISP_RVALID, prev_g); end
      if (prev_g && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++; if (DISP_RDATA !== e) begin bad++; $display("FAIL starve_rdata c%0d: got %h expected %h", k, DISP_RDATA, e); end
      end
      if (k == SMAX + 1) ref_mem[7] = d;
      if (exp_g) exp_q.push_back(ref_mem[DISP_ADDR]);
      prev_g = exp_g;
      @(posedge CLK); #1;
      if (k == SMAX + 1) begin AVL_CS = 1'b0; AVL_WRITE = 1'b0; end
    end
    DISP_REQ = 1'b0;
    @(negedge CLK);
    total++; if (DISP_RVALID !== 1'b1) begin bad++; $display("FAIL starve_last_rvalid: got %b expected 1", DISP_RVALID); end
    @(posedge CLK); #1;
  endtask

  task automatic test_rd_overlap();
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = 10'd3; DISP_REQ = 1'b0;
    @(negedge CLK);
    total++; if (AVL_WAITREQUEST !== 1'b1 || RAM_ADDR !== 10'd3 || RAM_WE !== 1'b0) begin bad++; $display("FAIL ovl_c1: got wait=%b addr=%0d we=%b expected 1/3/0", AVL_WAITREQUEST, RAM_ADDR, RAM_WE); end
    @(posedge CLK); #1;
    DISP_REQ = 1'b1; DISP_ADDR = 10'd4;
    @(negedge CLK);
    total++; if (AVL_WAITREQUEST !== 1'b0 || AVL_READDATA !== ref_mem[3]) begin bad++; $display("FAIL ovl_avl_data: got wait=%b data=%h expected 0/%h", AVL_WAITREQUEST, AVL_READDATA, ref_mem[3]); end
    total++; if (DISP_GNT !== 1'b1 || RAM_ADDR !== 10'd4) begin bad++; $display("FAIL ovl_disp_gnt: got gnt=%b addr=%0d expected 1/4", DISP_GNT, RAM_ADDR); end
    @(posedge CLK); #1;
    AVL_CS = 1'b0; AVL_READ = 1'b0; DISP_REQ = 1'b0;
    @(negedge CLK);
    total++; if (DISP_RVALID !== 1'b1 || DISP_RDATA !== ref_mem[4]) begin bad++; $display("FAIL ovl_disp_data: got v=%b data=%h expected 1/%h", DISP_RVALID, DISP_RDATA, ref_mem[4]); end
    @(posedge CLK); #1;
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    logic [31:0] e, op_data;
    logic [9:0]  op_addr;
    logic [3:0]  op_be;
    bit op_active, op_wr, op_phase2, prev_g, ram_op, ram_pend, granted, exp_g, exp_wait;
    int op_wait, sel;
    op_active = 1'b0; op_wr = 1'b0; op_phase2 = 1'b0; prev_g = 1'b0; op_wait = 0;
    op_addr = '0; op_data = '0; op_be = '0;
    for (int c = 0; c < 400; c++) begin
      if (!op_active && $urandom_range(0, 2) != 0) begin
        op_active = 1'b1; op_phase2 = 1'b0; op_wait = 0;
        op_wr = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 9);
        op_addr = (sel < 7) ? 10'($urandom_range(0, NW-1)) : (sel < 8) ? 10'(CA) : 10'($urandom_range(601, 1023));
        op_data = $urandom; op_be = 4'($urandom_range(0, 15));
        AVL_CS = 1'b1; AVL_READ = !op_wr; AVL_WRITE = op_wr;
        AVL_ADDR = op_addr; AVL_WRITEDATA = op_data; AVL_BYTE_EN = op_be;
      end
      DISP_REQ = ($urandom_range(0, 3) != 0);
      DISP_ADDR = 10'($urandom_range(0, NW-1));
      @(negedge CLK);
      if (op_active) op_wait++;
      ram_op   = op_addr < NW;
      ram_pend = op_active && ram_op && (op_wr || !op_phase2);
      exp_g    = DISP_REQ && !(ram_pend && op_wait == SMAX + 1);
      total++; if (CTRL_OUT !== ref_ctrl) begin bad++; $display("FAIL rnd_ctrl c%0d: got %h expected %h", c, CTRL_OUT, ref_ctrl); end
      total++; if (DISP_GNT !== exp_g) begin bad++; $display("FAIL rnd_gnt c%0d: got %b expected %b", c, DISP_GNT, exp_g); end
      total++; if (DISP_RVALID !== prev_g) begin bad++; $display("FAIL rnd_rvalid c%0d: got %b expected %b", c, DISP_RVALID, prev_g); end
      if (prev_g && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++; if (DISP_RDATA !== e) begin bad++; $display("FAIL rnd_rdata c%0d: got %h expected %h", c, DISP_RDATA, e); end
      end
      if (exp_g) begin
        total++; if (RAM_ADDR !== DISP_ADDR || RAM_WE !== 1'b0) begin bad++; $display("FAIL rnd_disp_pins c%0d: got addr=%0d we=%b expected %0d/0", c, RAM_ADDR, RAM_WE, DISP_ADDR); end
        exp_q.push_back(ref_mem[DISP_ADDR]);
      end
      prev_g = exp_g;
      if (op_active) begin
        if (!op_wr && op_phase2) begin
          e = ram_op ? ref_mem[op_addr] : (op_addr == 10'(CA)) ? ref_ctrl : 32'h0;
          total++; if (AVL_WAITREQUEST !== 1'b0 || AVL_READDATA !== e) begin bad++; $display("FAIL rnd_read c%0d addr=%0d: got wait=%b data=%h expected 0/%h", c, op_addr, AVL_WAITREQUEST, AVL_READDATA, e); end
          op_active = 1'b0;
        end else begin
          granted  = !ram_op || !exp_g;
          exp_wait = op_wr ? !granted : 1'b1;
          total++; if (AVL_WAITREQUEST !== exp_wait) begin bad++; $display("FAIL rnd_wait c%0d addr=%0d: got %b expected %b", c, op_addr, AVL_WAITREQUEST, exp_wait); end
          if (granted && op_wr) begin
            if (ram_op) begin
              total++; if (RAM_ADDR !== op_addr || (op_be != 0 && (RAM_WE !== 1'b1 || RAM_BE !== op_be || RAM_WDATA !== op_data))) begin bad++; $display("FAIL rnd_wpins c%0d: got addr=%0d we=%b be=%h expected %0d/%h", c, RAM_ADDR, RAM_WE, RAM_BE, op_addr, op_be); end
              ref_mem[op_addr] = merge(ref_mem[op_addr], op_data, op_be);
            end else begin
              total++; if (RAM_WE !== 1'b0) begin bad++; $display("FAIL rnd_noram_we c%0d: got %b expected 0", c, RAM_WE); end
              if (op_addr == 10'(CA)) ref_ctrl = merge(ref_ctrl, op_data, op_be);
            end
            op_active = 1'b0;
          end else if (granted) begin
            op_phase2 = 1'b1;
          end
        end
      end
      @(posedge CLK); #1;
      if (!op_active) begin AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0; end
    end
    DISP_REQ = 1'b0; AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_inflight();
    int lat, wc; logic [9:0] wa; logic [31:0] rd, d;
    d = $urandom;
    avl_op(1'b1, 10'(CA), d, 4'hF, lat, wc, wa, rd);
    ref_ctrl = d;
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 10'd20; AVL_WRITEDATA = 32'hCAFEF00D; AVL_BYTE_EN = 4'hF;
    DISP_REQ = 1'b1; DISP_ADDR = 10'd21;
    @(negedge CLK);
    total++; if (DISP_GNT !== 1'b1) begin bad++; $display("FAIL rif_gnt1: got %b expected 1", DISP_GNT); end
    @(posedge CLK); #1;
    @(negedge CLK);
    total++; if (DISP_GNT !== 1'b1) begin bad++; $display("FAIL rif_gnt2: got %b expected 1", DISP_GNT); end
    @(posedge CLK); #1;
    RESET = 1'b0; AVL_CS = 1'b0; AVL_WRITE = 1'b0; DISP_REQ = 1'b0;
    @(negedge CLK);
    total++; if (DISP_RVALID !== 1'b0) begin bad++; $display("FAIL rif_rvalid_in_reset: got %b expected 0", DISP_RVALID); end
    @(posedge CLK); #1;
    RESET = 1'b1;
    ref_ctrl = CTRL_RST;
    @(negedge CLK);
    total++; if (DISP_RVALID !== 1'b0) begin bad++; $display("FAIL rif_rvalid_after: got %b expected 0", DISP_RVALID); end
    total++; if (CTRL_OUT !== CTRL_RST) begin bad++; $display("FAIL rif_ctrl: got %h expected %h", CTRL_OUT, CTRL_RST); end
    total++; if (dut.starve_q !== '0) begin bad++; $display("FAIL rif_starve: got %0d expected 0", dut.starve_q); end
    @(posedge CLK); #1;
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = 10'd30;
    @(negedge CLK);
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    total++; if (AVL_WAITREQUEST !== 1'b1) begin bad++; $display("FAIL rif_avl_no_complete: got %b expected 1", AVL_WAITREQUEST); end
    @(posedge CLK); #1;
    AVL_CS = 1'b0; AVL_READ = 1'b0; RESET = 1'b1;
    avl_op(1'b0, 10'd30, 32'h0, 4'h0, lat, wc, wa, rd);
    total++; if (lat != 2 || rd !== ref_mem[30]) begin bad++; $display("FAIL rif_read_after: got lat=%0d data=%h expected 2/%h", lat, rd, ref_mem[30]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NW; i++) ref_mem[i] = seed_val(i);
    ref_ctrl = CTRL_RST;
    test_reset();
    test_ctrl();
    test_write_read();
    test_oob();
    test_starvation();
    test_rd_overlap();
    test_random();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port text-mode VRAM (600 glyph words plus one control word) between the Avalon-MM slave port and the display character fetcher. It issues at most one RAM operation per cycle and gives the display priority, with a starvation bound for the CPU. The block also holds the colour control register locally and drives the RAM's address, write-enable and byte-lane pins. It sits between the Avalon fabric, the VRAM macro and the text renderer inside the VGA text IP.

## Interface
Parameters:
- ADDR_W, 10, word address width (Avalon and display)
- DATA_W, 32, word width
- VRAM_WORDS, 600, number of glyph words backed by RAM (addresses 0..599)
- CTRL_ADDR, 600, address of the control register
- STARVE_MAX, 4, maximum number of consecutive cycles a pending Avalon access can lose to the display

Ports:
- CLK  in  1  system clock, 50 MHz
- RESET  in  1  synchronous, active-low reset
- AVL_CS, AVL_READ, AVL_WRITE  in  1 each  Avalon-MM slave controls
- AVL_BYTE_EN  in  4  byte lanes
- AVL_ADDR  in  ADDR_W  word address
- AVL_WRITEDATA  in  DATA_W  write data
- AVL_READDATA  out  DATA_W  read data, valid in the cycle AVL_WAITREQUEST is low
- AVL_WAITREQUEST  out  1  combinational stall
- DISP_REQ  in  1  display fetch request
- DISP_ADDR  in  ADDR_W  fetch address (0..599)
- DISP_GNT  out  1  combinational grant; the request is issued this cycle
- DISP_RDATA  out  DATA_W  fetched word
- DISP_RVALID  out  1  registered; high for 1 cycle, one cycle after DISP_GNT
- RAM_ADDR  out  ADDR_W  RAM address
- RAM_WE  out  1  RAM write enable
- RAM_BE  out  4  RAM byte enables
- RAM_WDATA  out  DATA_W  RAM write data
- RAM_RDATA  in  DATA_W  RAM read data; synchronous RAM, valid one cycle after the address is issued
- CTRL_OUT  out  DATA_W  control register contents, fed to the renderer

## Operation
- An Avalon access is pending when AVL_CS and (AVL_READ or AVL_WRITE) are high and no Avalon read is in flight. AVL_READ and AVL_WRITE are never both high.
- RAM-port priority in each cycle:
  - If starve_cnt equals STARVE_MAX and an Avalon RAM access is pending, Avalon wins.
  - Otherwise, if DISP_REQ is high, the display wins.
  - Otherwise, a pending Avalon RAM access wins.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, in each cycle an Avalon RAM access is pending and not granted.
  - Clears on the Avalon grant.
- Avalon write to 0..599:
  - In the grant cycle, drive RAM_WE=1, RAM_BE=AVL_BYTE_EN, RAM_ADDR and RAM_WDATA.
  - AVL_WAITREQUEST is low in the grant cycle.
  - Byte enable 0000: no RAM write; the access still completes as normal.
- Avalon read of 0..599:
  - Grant cycle: RAM read issued, AVL_WAITREQUEST high; FSM goes to AVL_RD.
  - Next cycle: AVL_READDATA = RAM_RDATA and AVL_WAITREQUEST low; FSM returns to IDLE.
- CTRL_ADDR access: never uses the RAM and never waits on the display.
  - Write: updates CTRL_OUT per byte lane and completes in the same cycle.
  - Read: takes the same two-cycle AVL_RD path as a RAM read and returns CTRL_OUT.
- Addresses 601..1023:
  - Writes are dropped and complete in one cycle.
  - Reads return 0 via AVL_RD.
- FSM states:
  - IDLE: no Avalon read is in flight.
  - AVL_RD: read data is returning. The RAM port is free in this cycle, so a display grant may be issued.
  - Only Avalon reads leave IDLE.
- Display fetch:
  - In a DISP_GNT cycle, RAM_ADDR = DISP_ADDR and RAM_WE=0.
  - In the next cycle, DISP_RDATA = RAM_RDATA and DISP_RVALID=1.
  - DISP_ADDR ≥ 600 is still granted; the fetched data is don't-care.
- Back-to-back display grants in every cycle are allowed: one fetch per cycle, fully pipelined.
- Same-cycle ordering: a display read and an Avalon write to the same word can never share a cycle, because there is one port. The later-issued operation observes the earlier one.

## Timing
- Reset values:
  - AVL_WAITREQUEST=1 while AVL_CS is high, otherwise 0.
  - DISP_GNT=0, DISP_RVALID=0, RAM_WE=0, RAM_BE=0, RAM_ADDR=0, RAM_WDATA=0.
  - AVL_READDATA=0, DISP_RDATA=0, CTRL_OUT=0x01FFE000 (white foreground, black background).
  - FSM=IDLE, starve_cnt=0.
- Latencies:
  - Avalon write: 1 cycle when the RAM port is uncontended.
  - Avalon read: 2 cycles.
  - Worst-case Avalon wait under continuous DISP_REQ: STARVE_MAX + 1 cycles before the grant.
- Reset asserted while a read is in flight: the read is discarded, DISP_RVALID stays 0, and no Avalon completion is produced.

## Structure
- Package vga_text_pkg holds:
  - Constants VRAM_WORDS, CTRL_ADDR and CTRL_RESET=32'h01FFE000.
  - Enum arb_state_t {IDLE, AVL_RD}.
  - Enum rd_src_t {SRC_RAM, SRC_CTRL, SRC_ZERO}, which selects the AVL_RD data source.
- One sub-module: vga_ctrl_reg, the byte-laned control register with its reset value.

## Test plan
- Uncontended Avalon write 0xDEADBEEF to address 5 with byte enable 1111:
  - Expect RAM_WE pulses 1 cycle with RAM_ADDR=5 and AVL_WAITREQUEST low in the same cycle.
  - A read of address 5 then returns 0xDEADBEEF in cycle 2.
- DISP_REQ held high for 10 cycles while an Avalon write to 7 is pending:
  - Expect the Avalon grant exactly at cycle STARVE_MAX+1=5, DISP_GNT low only in that cycle.
  - DISP_RVALID follows each grant by 1 cycle.
- Partial write with byte enable 0010 and data 0x0000AB00 to CTRL_ADDR after reset:
  - Expect CTRL_OUT=0x01FFAB00.
  - A CTRL_ADDR read returns 0x01FFAB00 with no RAM activity.
- Out-of-range access to address 700:
  - Write: expect no RAM_WE and a 1-cycle completion.
  - Read: expect 0 after 2 cycles.
- Avalon read to 3 issued, display request to 4 in the AVL_RD cycle:
  - Expect AVL_READDATA=mem[3] in that cycle.
  - DISP_RDATA=mem[4] one cycle later.
- RESET driven low in the cycle after a display grant:
  - Expect DISP_RVALID to stay 0, CTRL_OUT=0x01FFE000 and starve_cnt=0.
